// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard controller.
// Holds the decoder states, the scan-code byte values and the event record.
package ps2_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StGotE0,
      StGotF0,
      StGotE1
   } state_e;

   localparam logic [7:0] CodeE0 = 8'hE0;
   localparam logic [7:0] CodeE1 = 8'hE1;
   localparam logic [7:0] CodeF0 = 8'hF0;
   localparam logic [7:0] CodeAA = 8'hAA;
   localparam logic [7:0] CodeFC = 8'hFC;
   localparam logic [7:0] CodeFA = 8'hFA;
   localparam logic [7:0] CodeFE = 8'hFE;
   localparam logic [7:0] CodeEE = 8'hEE;

   typedef struct packed {
      logic       ext;
      logic       brk;
      logic [7:0] code;
   } evt_t;

   localparam int unsigned EvtW = $bits(evt_t);

   function automatic logic is_dev_err(input logic [7:0] b);
      return (b == CodeFC) || (b == 8'h00) || (b == 8'hFF);
   endfunction

   // Acknowledge, resend and echo replies carry no key information.
   function automatic logic is_reply(input logic [7:0] b);
      return (b == CodeFA) || (b == CodeFE) || (b == CodeEE);
   endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// Synchronous event FIFO with power-of-two depth and same-cycle push/pop.
// A push while full is accepted only when a pop frees a slot on the same edge.
module ps2_evt_fifo #(
   parameter int unsigned Depth = 4,
   parameter int unsigned Width = 10
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic [Width-1:0] wdata_i,
   input  logic             pop_i,
   output logic [Width-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int unsigned PtrW = $clog2(Depth);
   localparam int unsigned CntW = PtrW + 1;

   logic [Width-1:0] mem_q [Depth];
   logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]  count_q, count_d;
   logic             do_push, do_pop;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == CntW'(Depth));
   assign do_pop  = pop_i & ~empty_o;
   assign do_push = push_i & (~full_o | do_pop);
   assign rdata_o = mem_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         wr_ptr_d = wr_ptr_q + PtrW'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      if (do_push && !do_pop) begin
         count_d = count_q + CntW'(1);
      end else if (do_pop && !do_push) begin
         count_d = count_q - CntW'(1);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= wdata_i;
      end
   end

endmodule

// File: rtl/ps2_kbd_ctrl.sv
// PS/2 keyboard protocol layer: turns raw scan-code bytes into make/break events,
// flags device status bytes and queues events for the host.
module ps2_kbd_ctrl #(
   parameter int unsigned FIFO_DEPTH  = 4,
   parameter int unsigned TIMEOUT_CYC = 2_500_000
) (
   input  logic       clk_ps2_rx,
   input  logic       reset_ps2_rx,
   input  logic       ctrl_en,
   input  logic       rx_done_tick,
   input  logic [7:0] rx_data,
   output logic       rx_en,
   output logic       evt_valid,
   input  logic       evt_ready,
   output logic [7:0] evt_code,
   output logic       evt_ext,
   output logic       evt_brk,
   output logic       bat_ok,
   output logic       dev_err,
   output logic       seq_timeout,
   output logic       evt_overflow
);
   import ps2_pkg::*;

   localparam int unsigned TmoW = $clog2(TIMEOUT_CYC);
   localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYC - 1);

   state_e          state_q, state_d;
   logic            ext_q, ext_d;
   logic [2:0]      skip_q, skip_d;
   logic [TmoW-1:0] tmo_q, tmo_d;
   logic            rx_en_q;
   logic            bat_ok_q, bat_ok_d;
   logic            dev_err_q, dev_err_d;
   logic            seq_timeout_q, seq_timeout_d;
   logic            overflow_q, overflow_d;

   logic            push;
   evt_t            push_evt;
   evt_t            head_evt;
   logic            fifo_full, fifo_empty;

   always_comb begin
      state_d       = state_q;
      ext_d         = ext_q;
      skip_d        = skip_q;
      tmo_d         = tmo_q;
      push          = 1'b0;
      push_evt      = '0;
      bat_ok_d      = 1'b0;
      dev_err_d     = 1'b0;
      seq_timeout_d = 1'b0;

      if (!ctrl_en) begin
         state_d = StIdle;
         ext_d   = 1'b0;
         skip_d  = '0;
         tmo_d   = '0;
      end else if (rx_done_tick) begin
         tmo_d = '0;
         unique case (state_q)
            StIdle: begin
               if (rx_data == CodeE0) begin
                  state_d = StGotE0;
                  ext_d   = 1'b1;
               end else if (rx_data == CodeF0) begin
                  state_d = StGotF0;
                  ext_d   = 1'b0;
               end else if (rx_data == CodeE1) begin
                  state_d = StGotE1;
                  skip_d  = 3'd7;
               end else if (rx_data == CodeAA) begin
                  bat_ok_d = 1'b1;
               end else if (is_dev_err(rx_data)) begin
                  dev_err_d = 1'b1;
               end else if (!is_reply(rx_data)) begin
                  push          = 1'b1;
                  push_evt.code = rx_data;
               end
            end
            StGotE0: begin
               if (rx_data == CodeF0) begin
                  state_d = StGotF0;
               end else if (rx_data != CodeE0) begin
                  push          = 1'b1;
                  push_evt.ext  = 1'b1;
                  push_evt.code = rx_data;
                  state_d       = StIdle;
               end
            end
            StGotF0: begin
               push          = 1'b1;
               push_evt.ext  = ext_q;
               push_evt.brk  = 1'b1;
               push_evt.code = rx_data;
               state_d       = StIdle;
               ext_d         = 1'b0;
            end
            StGotE1: begin
               // Pause is reported once, after its fixed-length tail is consumed.
               skip_d = skip_q - 3'd1;
               if (skip_q == 3'd1) begin
                  push          = 1'b1;
                  push_evt.ext  = 1'b1;
                  push_evt.code = CodeE1;
                  state_d       = StIdle;
               end
            end
            default: state_d = StIdle;
         endcase
      end else if (state_q == StIdle) begin
         tmo_d = '0;
      end else if (tmo_q == TmoLast) begin
         state_d       = StIdle;
         ext_d         = 1'b0;
         tmo_d         = '0;
         seq_timeout_d = 1'b1;
      end else begin
         tmo_d = tmo_q + TmoW'(1);
      end
   end

   // When full, the FIFO is non-empty, so a ready host always frees a slot.
   assign overflow_d = push & fifo_full & ~evt_ready;

   always_ff @(posedge clk_ps2_rx or posedge reset_ps2_rx) begin
      if (reset_ps2_rx) begin
         state_q       <= StIdle;
         ext_q         <= 1'b0;
         skip_q        <= '0;
         tmo_q         <= '0;
         rx_en_q       <= 1'b0;
         bat_ok_q      <= 1'b0;
         dev_err_q     <= 1'b0;
         seq_timeout_q <= 1'b0;
         overflow_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         ext_q         <= ext_d;
         skip_q        <= skip_d;
         tmo_q         <= tmo_d;
         rx_en_q       <= ctrl_en & ~fifo_full;
         bat_ok_q      <= bat_ok_d;
         dev_err_q     <= dev_err_d;
         seq_timeout_q <= seq_timeout_d;
         overflow_q    <= overflow_d;
      end
   end

   ps2_evt_fifo #(
      .Depth (FIFO_DEPTH),
      .Width (EvtW)
   ) u_evt_fifo (
      .clk_i   (clk_ps2_rx),
      .rst_i   (reset_ps2_rx),
      .push_i  (push),
      .wdata_i (push_evt),
      .pop_i   (evt_ready),
      .rdata_o (head_evt),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   // Storage is not reset, so the head fields are masked while nothing is queued.
   assign evt_valid    = ~fifo_empty;
   assign evt_code     = fifo_empty ? 8'h00 : head_evt.code;
   assign evt_ext      = ~fifo_empty & head_evt.ext;
   assign evt_brk      = ~fifo_empty & head_evt.brk;
   assign rx_en        = rx_en_q;
   assign bat_ok       = bat_ok_q;
   assign dev_err      = dev_err_q;
   assign seq_timeout  = seq_timeout_q;
   assign evt_overflow = overflow_q;

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Directed bench for ps2_kbd_ctrl: decoding, status pulses, FIFO full/overflow,
// sequence timeout, enable drop and mid-sequence reset.
module tb_ps2_kbd_ctrl;

   logic       clk_ps2_rx;
   logic       reset_ps2_rx;
   logic       ctrl_en;
   logic       rx_done_tick;
   logic [7:0] rx_data;
   logic       rx_en;
   logic       evt_valid;
   logic       evt_ready;
   logic [7:0] evt_code;
   logic       evt_ext;
   logic       evt_brk;
   logic       bat_ok;
   logic       dev_err;
   logic       seq_timeout;
   logic       evt_overflow;

   int checks   = 0;
   int failures = 0;
   int tmo_seen;

   ps2_kbd_ctrl #(
      .FIFO_DEPTH  (4),
      .TIMEOUT_CYC (100)
   ) dut (
      .clk_ps2_rx   (clk_ps2_rx),
      .reset_ps2_rx (reset_ps2_rx),
      .ctrl_en      (ctrl_en),
      .rx_done_tick (rx_done_tick),
      .rx_data      (rx_data),
      .rx_en        (rx_en),
      .evt_valid    (evt_valid),
      .evt_ready    (evt_ready),
      .evt_code     (evt_code),
      .evt_ext      (evt_ext),
      .evt_brk      (evt_brk),
      .bat_ok       (bat_ok),
      .dev_err      (dev_err),
      .seq_timeout  (seq_timeout),
      .evt_overflow (evt_overflow)
   );

   initial begin
      clk_ps2_rx = 1'b0;
      forever #5 clk_ps2_rx = ~clk_ps2_rx;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; the byte is sampled on the next posedge.
   task automatic tick(input logic [7:0] b);
      rx_data      = b;
      rx_done_tick = 1'b1;
      @(negedge clk_ps2_rx);
      rx_done_tick = 1'b0;
   endtask

   task automatic pop();
      evt_ready = 1'b1;
      @(negedge clk_ps2_rx);
      evt_ready = 1'b0;
   endtask

   // exp = {ext, brk, code}
   task automatic expect_evt(input string tag, input logic [9:0] exp);
      chk({tag, "_valid"}, 32'(evt_valid), 32'd1);
      chk(tag, 32'({evt_ext, evt_brk, evt_code}), 32'(exp));
      pop();
   endtask

   logic [7:0] pause_seq [8];

   initial begin
      pause_seq[0] = 8'hE1; pause_seq[1] = 8'h14; pause_seq[2] = 8'h77;
      pause_seq[3] = 8'hE1; pause_seq[4] = 8'hF0; pause_seq[5] = 8'h14;
      pause_seq[6] = 8'hF0; pause_seq[7] = 8'h77;

      reset_ps2_rx = 1'b1;
      ctrl_en      = 1'b0;
      rx_done_tick = 1'b0;
      rx_data      = 8'h00;
      evt_ready    = 1'b0;
      repeat (3) @(negedge clk_ps2_rx);
      chk("reset_outputs", 32'({rx_en, evt_valid, evt_code, evt_ext, evt_brk}), 32'd0);
      chk("reset_pulses", 32'({bat_ok, dev_err, seq_timeout, evt_overflow}), 32'd0);

      reset_ps2_rx = 1'b0;
      @(negedge clk_ps2_rx);
      ctrl_en = 1'b1;
      chk("rx_en_before_edge", 32'(rx_en), 32'd0);
      @(negedge clk_ps2_rx);
      chk("rx_en_after_edge", 32'(rx_en), 32'd1);

      // Plain make, then break.
      tick(8'h1C);
      expect_evt("make_1c", 10'h01C);
      tick(8'hF0);
      chk("no_evt_after_f0", 32'(evt_valid), 32'd0);
      tick(8'h1C);
      expect_evt("break_1c", 10'h11C);

      // Extended make and break, with a repeated E0 prefix.
      tick(8'hE0);
      tick(8'h75);
      expect_evt("ext_make_75", 10'h275);
      tick(8'hE0);
      tick(8'hE0);
      tick(8'hF0);
      tick(8'h75);
      expect_evt("ext_break_75", 10'h375);

      // Pause: eight bytes produce exactly one event.
      for (int i = 0; i < 8; i++) begin
         tick(pause_seq[i]);
         if (i == 6) chk("pause_not_early", 32'(evt_valid), 32'd0);
      end
      expect_evt("pause_evt", 10'h2E1);
      chk("pause_single", 32'(evt_valid), 32'd0);

      // Status bytes and ignored replies.
      tick(8'hAA);
      chk("bat_ok_pulse", 32'(bat_ok), 32'd1);
      @(negedge clk_ps2_rx);
      chk("bat_ok_one_cycle", 32'(bat_ok), 32'd0);
      tick(8'hFC);
      chk("dev_err_pulse", 32'(dev_err), 32'd1);
      @(negedge clk_ps2_rx);
      chk("dev_err_one_cycle", 32'(dev_err), 32'd0);
      tick(8'hFA);
      tick(8'h00);
      chk("dev_err_00", 32'(dev_err), 32'd1);
      chk("no_status_events", 32'(evt_valid), 32'd0);

      // Fill the FIFO, overflow it, then push and pop together.
      tick(8'h11);
      tick(8'h22);
      tick(8'h33);
      tick(8'h44);
      chk("rx_en_lags_full", 32'(rx_en), 32'd1);
      @(negedge clk_ps2_rx);
      chk("rx_en_full", 32'(rx_en), 32'd0);
      tick(8'h55);
      chk("overflow_pulse", 32'(evt_overflow), 32'd1);
      chk("head_stable", 32'({evt_ext, evt_brk, evt_code}), 32'h011);
      @(negedge clk_ps2_rx);
      chk("overflow_one_cycle", 32'(evt_overflow), 32'd0);
      rx_data      = 8'h66;
      rx_done_tick = 1'b1;
      evt_ready    = 1'b1;
      @(negedge clk_ps2_rx);
      rx_done_tick = 1'b0;
      evt_ready    = 1'b0;
      chk("no_overflow_on_pop", 32'(evt_overflow), 32'd0);
      expect_evt("fifo_22", 10'h022);
      expect_evt("fifo_33", 10'h033);
      expect_evt("fifo_44", 10'h044);
      expect_evt("fifo_66", 10'h066);
      chk("fifo_drained", 32'(evt_valid), 32'd0);
      chk("rx_en_restored", 32'(rx_en), 32'd1);

      // Abandoned E0 sequence times out after exactly TIMEOUT_CYC clocks.
      tick(8'hE0);
      tmo_seen = 0;
      for (int j = 1; j <= 150 && tmo_seen == 0; j++) begin
         @(negedge clk_ps2_rx);
         if (seq_timeout) tmo_seen = j;
      end
      chk("timeout_latency", 32'(tmo_seen), 32'd100);
      @(negedge clk_ps2_rx);
      chk("timeout_one_cycle", 32'(seq_timeout), 32'd0);
      chk("timeout_no_push", 32'(evt_valid), 32'd0);
      tick(8'h1C);
      expect_evt("after_timeout", 10'h01C);

      // Dropping ctrl_en abandons a pending break prefix.
      tick(8'hF0);
      ctrl_en = 1'b0;
      @(negedge clk_ps2_rx);
      ctrl_en = 1'b1;
      tick(8'h1C);
      expect_evt("after_disable", 10'h01C);

      // Reset in the middle of a pause sequence with an event queued.
      tick(8'h1C);
      tick(8'hE1);
      tick(8'h14);
      reset_ps2_rx = 1'b1;
      #1;
      chk("midreset_outputs", 32'({rx_en, evt_valid, evt_code, evt_ext, evt_brk}), 32'd0);
      chk("midreset_pulses", 32'({bat_ok, dev_err, seq_timeout, evt_overflow}), 32'd0);
      @(negedge clk_ps2_rx);
      reset_ps2_rx = 1'b0;
      @(negedge clk_ps2_rx);
      tick(8'h77);
      expect_evt("after_reset", 10'h077);
      chk("after_reset_empty", 32'(evt_valid), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
